keypad_scanner: RTL

- Scans a 4x4 matrix keypad: drives one row low at a time, reads the four column inputs, debounces, and reports single key presses as a code plus a one-cycle valid strobe.
- Input-side counterpart of the multiplexed display driver: that block writes digits out by scanning, this block reads keys in by scanning.
- Pacing uses an internal scan-tick enable, not a derived clock, so all logic stays on clk.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_if.sv | 12 +
 rtl/scan_tick_gen.sv | 16 +
 rtl/keypad_scanner.sv | 120 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sizes, FSM/frame-class enums and the frame classifier for the keypad scanner
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEY_W = $clog2(ROWS * COLS);
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;
  typedef enum logic [1:0] {NONE, ONE, MULTI} fclass_t;
  typedef struct packed {
    fclass_t cls;
    logic [KEY_W-1:0] code;
  } frame_t;
  function automatic frame_t classify(input logic [ROWS*COLS-1:0] hits);
    frame_t f;
    int n;
    n = 0;
    f.code = '0;
    for (int i = 0; i < ROWS * COLS; i++)
      if (hits[i]) begin
        n++;
        f.code = KEY_W'(i);
      end
    f.cls = n == 0 ? NONE : n == 1 ? ONE : MULTI;
    return f;
  endfunction
endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad bus; master=scanner (en, cols in; rows, key_code, key_valid, key_held out), slave=environment
interface keypad_if;
  import keypad_pkg::*;
  logic en;
  logic [COLS-1:0] cols;
  logic [ROWS-1:0] rows;
  logic [KEY_W-1:0] key_code;
  logic key_valid;
  logic key_held;
  modport master(input en, cols, output rows, key_code, key_valid, key_held);
  modport slave(output en, cols, input rows, key_code, key_valid, key_held);
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: one-cycle tick every DIV enabled clk cycles; ports clk, reset, en in, tick out
module scan_tick_gen #(
  parameter int DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scan + frame debounce; ports clk, reset, bus (keypad_if.master)
module keypad_scanner import keypad_pkg::*; #(
  parameter int SCAN_DIV = 250000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES);
  localparam int RW = $clog2(ROWS);
  logic [COLS-1:0] s1, s2;
  logic tick, last_row, fdone, step, accept, drop;
  logic [RW-1:0] row_idx;
  logic [ROWS*COLS-1:0] acc, acc_n;
  frame_t frame;
  state_t state, state_n;
  logic [KEY_W-1:0] cand, cand_n, code, code_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid, valid_n, held, held_n;
  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .reset(reset), .en(bus.en), .tick(tick));
  assign last_row = tick && row_idx == RW'(ROWS - 1);
  assign step = fdone && bus.en;
  assign bus.rows = ~(ROWS'(1) << row_idx);
  assign bus.key_code = code;
  assign bus.key_valid = valid;
  assign bus.key_held = held;
  // accumulator holds active-high hits so a cleared accumulator means no key
  always_comb begin
    acc_n = acc;
    acc_n[row_idx*COLS +: COLS] = ~s2;
  end
  // fdone is held while en=0 so a frame finished just before a pause is acted on at resume
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      row_idx <= '0;
      acc <= '0;
      fdone <= 1'b0;
      frame <= '0;
    end else begin
      s1 <= bus.cols;
      s2 <= s1;
      if (bus.en) fdone <= last_row;
      if (tick) begin
        acc <= acc_n;
        row_idx <= row_idx + 1'b1;
      end
      if (last_row) frame <= classify(acc_n);
    end
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    code_n = code;
    held_n = held;
    valid_n = 1'b0;
    accept = 1'b0;
    drop = 1'b0;
    if (step)
      case (state)
        IDLE:
          if (frame.cls == ONE) begin
            cand_n = frame.code;
            cnt_n = CW'(1);
            state_n = CAND;
            accept = DEBOUNCE_FRAMES == 1;
          end
        CAND:
          if (frame.cls != ONE) state_n = IDLE;
          else if (frame.code != cand) begin
            cand_n = frame.code;
            cnt_n = CW'(1);
          end else begin
            cnt_n = cnt + 1'b1;
            accept = cnt_n == LAST;
          end
        PRESSED:
          if (frame.cls == NONE) begin
            cnt_n = CW'(1);
            state_n = REL;
            drop = DEBOUNCE_FRAMES == 1;
          end
        REL:
          if (frame.cls != NONE) state_n = PRESSED;
          else begin
            cnt_n = cnt + 1'b1;
            drop = cnt_n == LAST;
          end
      endcase
    if (accept) begin
      state_n = PRESSED;
      code_n = cand_n;
      valid_n = 1'b1;
      held_n = 1'b1;
    end
    if (drop) begin
      state_n = IDLE;
      held_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      code <= '0;
      valid <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      cnt <= cnt_n;
      code <= code_n;
      valid <= valid_n;
      held <= held_n;
    end
endmodule
